micro_sequencer: RTL
====================

Name: micro_sequencer

Overview:
- Micro-program sequencer for the matrix-multiply core control unit; it sits on the other side of the microcode ROM interface.
- It drives the ROM address (`reg_out`) and consumes the ROM fields `BT`, `condition` and `jump_addr` to compute the next micro-address each clock.
- It handles opcode dispatch, Z-flag conditional branches, memory stalls, halt/start control and illegal-opcode recovery.
- `OPs` does not pass through this block; it goes straight to the datapath.

Parameters:
- `UADDR_W`, 16, width of the micro-address output `reg_out`.
- `UCODE_DEPTH`, 75, number of valid micro-addresses; valid range is 0..UCODE_DEPTH-1.
- `OPCODE_W`, 8, width of the instruction-register opcode field.
- `HALT_OPCODE`, 8'hFF, opcode that stops the sequencer.

Ports:
- `clk`, input, 1, system clock, rising edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `start`, input, 1, single-cycle pulse; leaves IDLE or HALT.
- `BT`, input, 1, dispatch flag from the current microinstruction.
- `condition`, input, 2, branch condition from the current microinstruction.
- `jump_addr`, input, 7, next/branch address from the current microinstruction.
- `z_flag`, input, 1, ALU zero flag, valid in the same cycle as the microinstruction.
- `ir_opcode`, input, OPCODE_W, opcode of the instruction register.
- `mem_stall`, input, 1, memory not ready; freezes sequencing.
- `reg_out`, output, UADDR_W, registered micro-address fed to the ROM.
- `running`, output, 1, high in the RUN state.
- `halted`, output, 1, high in the HALT state.
- `illegal_op`, output, 1, one-cycle pulse on an out-of-range dispatch.

Behaviour:
- **Reset.** `rst_n`=0 acts immediately, also mid-operation:
  - `reg_out`=0, state=IDLE.
  - `running`=0, `halted`=0, `illegal_op`=0.
- **States:** IDLE, RUN, HALT.
- **IDLE.**
  - `reg_out` is held at 0.
  - `start`=1 → RUN at the next edge; `reg_out` stays 0 on that edge.
- **RUN.** Next-address selection on each edge, evaluated in priority order:
  1. `mem_stall`=1: `reg_out` holds its value and no other field is evaluated. A stall has priority over everything in RUN.
  2. `BT`=1 (dispatch): `BT` overrides `condition`.
     - `ir_opcode`==HALT_OPCODE → HALT, `reg_out`←0.
     - Otherwise, if `ir_opcode` < UCODE_DEPTH → `reg_out`←`ir_opcode`, zero-extended.
     - Otherwise → `reg_out`←0 and `illegal_op`=1 for exactly the following cycle.
  3. `condition`=2'b01: `z_flag`=1 → `jump_addr`; `z_flag`=0 → `reg_out`+1.
  4. `condition`=2'b10: `z_flag`=0 → `jump_addr`; `z_flag`=1 → `reg_out`+1.
  5. `condition`=2'b00 or 2'b11 (11 is reserved): unconditional → `jump_addr`, zero-extended.
- **Range and wrap rules.**
  - `jump_addr`=0 means "return to fetch" and is not special-cased.
  - Any computed next address ≥ UCODE_DEPTH (including `reg_out`+1 overflow past the last entry) → `reg_out`←0 and `illegal_op` pulses.
  - No wrap-around beyond 0 occurs.
- **HALT.**
  - `reg_out` is held at 0 and `halted`=1.
  - `start` → RUN at the next edge.
  - `mem_stall` is ignored.
- **Timing.**
  - `start` is ignored while in RUN.
  - Latency: the ROM output for `reg_out`=N is consumed in the same cycle; `reg_out` changes on the next rising edge. One microinstruction per unstalled cycle.
- **Output decode.** `running` and `halted` are registered state decodes.

Optional Feature:
- Macro: `MICRO_SEQ_PERF_EN`.
- When defined, the block adds two outputs:
  - `ucycle_cnt` [31:0]: counts RUN cycles with `mem_stall`=0.
  - `stall_cnt` [31:0]: counts RUN cycles with `mem_stall`=1.
- Counter behaviour:
  - Both counters saturate at 32'hFFFFFFFF.
  - Both reset to 0 on `rst_n` and on each `start` pulse taken from IDLE or HALT.
- When undefined, the ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset and start: assert `rst_n`=0 → `reg_out`=0, `running`=0, `halted`=0. Release, pulse `start` → `running`=1. ROM model gives jumps 0→1→2 → `reg_out` sequence 0,1,2.
- Dispatch: at `reg_out`=2 with `BT`=1 and `ir_opcode`=7 → next `reg_out`=7. Then the chain 8,9,10,0 follows `jump_addr`.
- Conditional branch: at `reg_out`=66 with `condition`=01 and `jump_addr`=69:
  - `z_flag`=1 → 69.
  - Repeat with `z_flag`=0 → 67.
  - `condition`=10 with `z_flag`=0 → 69.
- Stall: `mem_stall`=1 for 3 cycles at `reg_out`=5 → `reg_out` stays 5 for those 3 cycles. On release it moves to 6.
- Illegal/halt:
  - `BT`=1 with `ir_opcode`=100 → `reg_out`=0 and `illegal_op` high exactly one cycle.
  - `BT`=1 with `ir_opcode`=8'hFF → `halted`=1 and `reg_out` frozen at 0 with `mem_stall` toggling. `start` → `running`=1.
- Async reset mid-run: drop `rst_n` at `reg_out`=30 between clock edges → `reg_out`=0 and state IDLE immediately, without waiting for `clk`.

Source files
------------

// File: rtl/micro_sequencer_if.sv
// Microcode ROM side bundle of the micro-program sequencer: ROM fields and
// control inputs in, micro-address and status out.
interface micro_sequencer_if #(
    parameter int UADDR_W  = 16,
    parameter int OPCODE_W = 8
);
    logic                start;
    logic                BT;
    logic [1:0]          condition;
    logic [6:0]          jump_addr;
    logic                z_flag;
    logic [OPCODE_W-1:0] ir_opcode;
    logic                mem_stall;
    logic [UADDR_W-1:0]  reg_out;
    logic                running;
    logic                halted;
    logic                illegal_op;

    modport master (
        output start, BT, condition, jump_addr, z_flag, ir_opcode, mem_stall,
        input  reg_out, running, halted, illegal_op
    );

    modport slave (
        input  start, BT, condition, jump_addr, z_flag, ir_opcode, mem_stall,
        output reg_out, running, halted, illegal_op
    );
endinterface

// File: rtl/micro_sequencer.sv
// Micro-program sequencer: computes the next microcode ROM address each clock.
// Optional RUN/stall cycle counters are enabled with `define MICRO_SEQ_PERF_EN.
module micro_sequencer #(
    parameter int                  UADDR_W     = 16,
    parameter int                  UCODE_DEPTH = 75,
    parameter int                  OPCODE_W    = 8,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = 8'hFF
) (
    input  logic         clk,
    input  logic         rst_n,
    micro_sequencer_if.slave bus
`ifdef MICRO_SEQ_PERF_EN
    ,
    output logic [31:0]  ucycle_cnt,
    output logic [31:0]  stall_cnt
`endif
);
    localparam int EXT_W = UADDR_W + 1;
    localparam logic [EXT_W-1:0] DEPTH_X = EXT_W'(UCODE_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [UADDR_W-1:0]   addr_q, addr_d;
    logic                 illegal_q, illegal_d;
    logic                 running_q, halted_q;
    logic [EXT_W-1:0]     tgt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            illegal_q <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            illegal_q <= illegal_d;
            running_q <= (state_d == RUN);
            halted_q  <= (state_d == HALT);
        end
    end

    // One extra bit on the target so reg_out+1 past the last entry is caught.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        illegal_d = 1'b0;
        tgt       = '0;
        case (state_q)
            IDLE, HALT: begin
                addr_d = '0;
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                if (!bus.mem_stall) begin
                    if (bus.BT && (bus.ir_opcode == HALT_OPCODE)) begin
                        state_d = HALT;
                        addr_d  = '0;
                    end else begin
                        if (bus.BT) begin
                            tgt = EXT_W'(bus.ir_opcode);
                        end else begin
                            case (bus.condition)
                                2'b01:   tgt = bus.z_flag  ? EXT_W'(bus.jump_addr)
                                                           : {1'b0, addr_q} + EXT_W'(1);
                                2'b10:   tgt = !bus.z_flag ? EXT_W'(bus.jump_addr)
                                                           : {1'b0, addr_q} + EXT_W'(1);
                                default: tgt = EXT_W'(bus.jump_addr);
                            endcase
                        end
                        if (tgt >= DEPTH_X) begin
                            addr_d    = '0;
                            illegal_d = 1'b1;
                        end else begin
                            addr_d = tgt[UADDR_W-1:0];
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    always_comb begin
        bus.reg_out    = addr_q;
        bus.running    = running_q;
        bus.halted     = halted_q;
        bus.illegal_op = illegal_q;
    end

`ifdef MICRO_SEQ_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] ucycle_q, stall_q;
    logic        start_taken;

    assign start_taken = bus.start && ((state_q == IDLE) || (state_q == HALT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ucycle_q <= '0;
            stall_q  <= '0;
        end else if (start_taken) begin
            ucycle_q <= '0;
            stall_q  <= '0;
        end else if (state_q == RUN) begin
            if (bus.mem_stall) stall_q  <= sat_inc(stall_q);
            else               ucycle_q <= sat_inc(ucycle_q);
        end
    end

    assign ucycle_cnt = ucycle_q;
    assign stall_cnt  = stall_q;
`endif
endmodule
